// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// The pipeline WB stage (primary) shares one RF write port with a small FIFO of
// writes offered by multi-cycle units (secondary). The primary normally wins; a
// buffered secondary write drains whenever the primary is idle.
// Optional feature macro: RFARB_STARVE_GUARD_EN. When defined, a starvation
// counter forces a secondary write after STARVE_LIMIT consecutive lost cycles and
// stalls the primary for that cycle.
module rf_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_register,
  input  logic [31:0] i_wb_data,
  input  logic        i_sec_valid,
  input  logic [4:0]  i_sec_register,
  input  logic [31:0] i_sec_data,
  output logic        o_sec_ready,
  output logic        o_stall,
  output logic        o_reg_write,
  output logic [4:0]  o_write_register,
  output logic [31:0] o_write_data,
  output logic [31:0] o_pending
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  // Reject depths the pointer arithmetic cannot wrap correctly.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      STARVE_LIMIT < 1) begin : g_param_check
    $error("rf_write_arbiter: unsupported FIFO_DEPTH or STARVE_LIMIT");
  end

  logic [4:0]            reg_q  [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic not_empty;
  logic push;
  logic pop;
  logic forced;
  logic sec_win;
  logic pri_win;

  assign not_empty   = (count_q != '0);
  assign o_sec_ready = (count_q < DepthCnt);
  // Writes to x0 are accepted from the source but never stored.
  assign push        = i_sec_valid & o_sec_ready & (i_sec_register != 5'd0);

`ifdef RFARB_STARVE_GUARD_EN
  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIMIT);

  logic [StW-1:0] starve_q, starve_d;

  // Starvation count: cycles the buffer waited while the primary took the port.
  always_comb begin
    starve_d = '0;
    if (not_empty && pri_win) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign forced  = not_empty && (starve_q == StarveMax);
  assign o_stall = i_wb_valid & sec_win;
`else
  assign forced  = 1'b0;
  assign o_stall = 1'b0;
`endif

  // Grant decision; outputs are held quiet while reset is asserted.
  always_comb begin
    sec_win = ~reset & not_empty & (~i_wb_valid | forced);
    pri_win = ~reset & i_wb_valid & ~sec_win;
    pop     = sec_win;
  end

  // Write-port mux: buffer head, primary pass-through, or idle zeros.
  always_comb begin
    o_reg_write      = 1'b0;
    o_write_register = 5'd0;
    o_write_data     = 32'd0;
    if (sec_win) begin
      o_reg_write      = 1'b1;
      o_write_register = reg_q[rd_ptr_q];
      o_write_data     = data_q[rd_ptr_q];
    end else if (pri_win) begin
      o_reg_write      = (i_wb_register != 5'd0);
      o_write_register = i_wb_register;
      o_write_data     = i_wb_data;
    end
  end

  // FIFO bookkeeping: pointers wrap naturally since the depth is a power of two.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
  end

  // FIFO control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= i_sec_register;
      data_q[wr_ptr_q] <= i_sec_data;
    end
  end

  // Scoreboard-style pending mask for the hazard logic.
  always_comb begin
    o_pending = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) begin
        o_pending[reg_q[i]] = 1'b1;
      end
    end
    o_pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_rf_write_arbiter;

  localparam int unsigned Depth = 2;
  localparam int unsigned Limit = 4;
`ifdef RFARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        sec_valid;
  logic [4:0]  sec_reg;
  logic [31:0] sec_data;
  logic        sec_ready;
  logic        stall;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(
    .FIFO_DEPTH  (Depth),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_wb_valid      (wb_valid),
    .i_wb_register   (wb_reg),
    .i_wb_data       (wb_data),
    .i_sec_valid     (sec_valid),
    .i_sec_register  (sec_reg),
    .i_sec_data      (sec_data),
    .o_sec_ready     (sec_ready),
    .o_stall         (stall),
    .o_reg_write     (reg_write),
    .o_write_register(write_reg),
    .o_write_data    (write_data),
    .o_pending       (pending)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered writes and a lost-arbitration count.
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_starve = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(output logic e_rw, output logic [4:0] e_addr,
                                    output logic [31:0] e_data, output logic e_stall,
                                    output logic e_secwin, output logic e_ready,
                                    output logic [31:0] e_pend);
    bit ne, force_sec;
    e_rw = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_stall = 1'b0; e_secwin = 1'b0;
    e_ready = (mq.size() < Depth);
    e_pend = 32'd0;
    foreach (mq[i]) e_pend[mq[i].r] = 1'b1;
    if (!reset) begin
      ne        = (mq.size() != 0);
      force_sec = Guard && ne && (m_starve == Limit);
      e_secwin  = ne && (!wb_valid || force_sec);
      if (e_secwin) begin
        e_rw = 1'b1; e_addr = mq[0].r; e_data = mq[0].d; e_stall = wb_valid;
      end else if (wb_valid) begin
        e_rw = (wb_reg != 5'd0); e_addr = wb_reg; e_data = wb_data;
      end
    end
  endfunction

  // Advance the model on each edge with the inputs the DUT saw.
  always @(posedge clk or posedge reset) begin
    logic e_rw, e_stall, e_secwin, e_ready;
    logic [4:0] e_addr;
    logic [31:0] e_data, e_pend;
    int sz;
    if (reset) begin
      mq.delete();
      m_starve = 0;
    end else begin
      model_out(e_rw, e_addr, e_data, e_stall, e_secwin, e_ready, e_pend);
      sz = mq.size();
      if (e_secwin) void'(mq.pop_front());
      if (sec_valid && sz < Depth && sec_reg != 5'd0) mq.push_back('{r: sec_reg, d: sec_data});
      if (sz != 0 && !e_secwin && wb_valid) m_starve = (m_starve < Limit) ? m_starve + 1 : Limit;
      else m_starve = 0;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    logic e_rw, e_stall, e_secwin, e_ready;
    logic [4:0] e_addr;
    logic [31:0] e_data, e_pend;
    model_out(e_rw, e_addr, e_data, e_stall, e_secwin, e_ready, e_pend);
    check("model_reg_write", 32'(reg_write), 32'(e_rw));
    check("model_write_register", 32'(write_reg), 32'(e_addr));
    check("model_write_data", write_data, e_data);
    check("model_stall", 32'(stall), 32'(e_stall));
    check("model_sec_ready", 32'(sec_ready), 32'(e_ready));
    check("model_pending", pending, e_pend);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy;
    reset = 1'b1; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    sec_valid = 1'b0; sec_reg = 5'd0; sec_data = 32'd0;
    #1;
    check("rst_pending", pending, 32'd0);
    check("rst_sec_ready", 32'(sec_ready), 32'd1);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    step();
    step();

    // Release reset and offer a secondary write straight away; primary idle.
    reset = 1'b0;
    sec_valid = 1'b1; sec_reg = 5'd7; sec_data = 32'h11;
    #1;
    check("drain_no_bypass", 32'(reg_write), 32'd0);
    check("drain_pending_before", pending, 32'd0);
    step();
    sec_valid = 1'b0;
    #1;
    check("drain_reg_write", 32'(reg_write), 32'd1);
    check("drain_addr", 32'(write_reg), 32'd7);
    check("drain_data", write_data, 32'h11);
    check("drain_pending_set", pending, 32'h80);
    step();
    #1;
    check("drain_pending_clear", pending, 32'd0);
    check("drain_idle", 32'(reg_write), 32'd0);

    // Primary only.
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    check("pri_reg_write", 32'(reg_write), 32'd1);
    check("pri_addr", 32'(write_reg), 32'd5);
    check("pri_data", write_data, 32'hDEADBEEF);
    check("pri_stall", 32'(stall), 32'd0);

    // Fill the buffer behind a busy primary, then hold a third offer.
    wb_reg = 5'd3; wb_data = 32'h33;
    sec_valid = 1'b1; sec_reg = 5'd10; sec_data = 32'hA0;
    step();
    sec_reg = 5'd11; sec_data = 32'hB0;
    step();
    sec_reg = 5'd12; sec_data = 32'hC0;
    #1;
    check("full_ready", 32'(sec_ready), 32'd0);
    check("full_pending", pending, 32'h0000_0C00);
    check("full_pri_addr", 32'(write_reg), 32'd3);
    step();
    #1;
    check("full_held_ready", 32'(sec_ready), 32'd0);
    check("full_held_pending", pending, 32'h0000_0C00);
    wb_valid = 1'b0;
    #1;
    check("full_pop1_addr", 32'(write_reg), 32'd10);
    check("full_pop1_data", write_data, 32'hA0);
    step();
    #1;
    check("full_after_pop_ready", 32'(sec_ready), 32'd1);
    check("full_pop2_addr", 32'(write_reg), 32'd11);
    step();
    sec_valid = 1'b0;
    #1;
    check("full_third_addr", 32'(write_reg), 32'd12);
    check("full_third_data", write_data, 32'hC0);
    check("full_third_pending", pending, 32'h0000_1000);
    step();
    #1;
    check("full_empty_pending", pending, 32'd0);

    // Register zero on both sources.
    sec_valid = 1'b1; sec_reg = 5'd0; sec_data = 32'h5;
    step();
    sec_valid = 1'b0;
    #1;
    check("x0_sec_pending", pending, 32'd0);
    check("x0_sec_no_write", 32'(reg_write), 32'd0);
    check("x0_sec_ready", 32'(sec_ready), 32'd1);
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h77;
    #1;
    check("x0_pri_no_write", 32'(reg_write), 32'd0);
    check("x0_pri_stall", 32'(stall), 32'd0);

    // Starvation: reg 9 buffered while the primary is valid every cycle.
    wb_reg = 5'd1; wb_data = 32'h1;
    sec_valid = 1'b1; sec_reg = 5'd9; sec_data = 32'h99;
    step();
    sec_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("starve_pri_addr", 32'(write_reg), 32'd1);
      check("starve_pri_stall", 32'(stall), 32'd0);
      step();
    end
    #1;
`ifdef RFARB_STARVE_GUARD_EN
    check("starve_forced_addr", 32'(write_reg), 32'd9);
    check("starve_forced_data", write_data, 32'h99);
    check("starve_forced_stall", 32'(stall), 32'd1);
`else
    check("starve_off_addr", 32'(write_reg), 32'd1);
    check("starve_off_stall", 32'(stall), 32'd0);
`endif
    wb_valid = 1'b0;
    step();
    step();

    // Mid-operation reset with two entries buffered.
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h22;
    sec_valid = 1'b1; sec_reg = 5'd20; sec_data = 32'h200;
    step();
    sec_reg = 5'd21; sec_data = 32'h210;
    step();
    sec_valid = 1'b0;
    #1;
    check("mid_pending_before", pending, 32'h0030_0000);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_ready", 32'(sec_ready), 32'd1);
    check("mid_rst_reg_write", 32'(reg_write), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    wb_valid = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mid_post_no_write", 32'(reg_write), 32'd0);
      step();
    end

    // Randomized traffic in phases of differing primary load.
    busy = 55;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (n % 500 == 0) busy = (busy == 90) ? 30 : 90;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 249) == 0) reset = 1'b1;
      wb_valid  = ($urandom_range(0, 99) < busy);
      wb_reg    = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data   = $urandom;
      sec_valid = ($urandom_range(0, 99) < 50);
      sec_reg   = 5'($urandom_range(0, 7));
      sec_data  = $urandom;
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
